uart_tx_queue: RTL
==================

// Module: uart_tx_queue
// PURPOSE
//  Parametrised UART transmitter with an input FIFO, runtime baud divisor,
//  optional parity and 1/2 stop bits. Next generation of the single-byte
//  tx_start/tx_data/tx_busy transmitter: producer pushes words with
//  valid/ready, block serialises them back-to-back on ser_tx. Used both as
//  a user-project peripheral driving mprj_io and as the bench UART stimulus source.
// PARAMETERS
//  DATA_BITS   8   data bits per frame (5..9)
//  FIFO_DEPTH  8   FIFO entries, power of two (2..64)
//  DIV_WIDTH   16  width of clk_div
//  PARITY      0   0 none, 1 even, 2 odd
//  STOP_BITS   1   1 or 2
// PORTS
//  clock       in   1                     system clock, all logic on rising edge
//  resetb      in   1                     asynchronous reset, active low
//  clk_div     in   DIV_WIDTH             bit period = clk_div+1 clocks
//  tx_valid    in   1                     producer word valid
//  tx_data     in   DATA_BITS             word to send
//  tx_ready    out  1                     FIFO can accept a word
//  tx_clear    in   1                     flush FIFO (pulse)
//  ser_tx      out  1                     serial line, idle high
//  tx_busy     out  1                     frame in flight or FIFO non-empty
//  tx_done     out  1                     1-cycle pulse at end of each frame
//  fifo_level  out  $clog2(FIFO_DEPTH)+1  words currently queued
// BEHAVIOUR
//  Reset (resetb low, async): ser_tx=1, tx_ready=1, tx_busy=0, tx_done=0,
//   fifo_level=0, FSM=IDLE, FIFO pointers 0. Reset mid-frame aborts the frame, line high at once.
//  Push: tx_valid&&tx_ready at a rising edge. tx_ready = (fifo_level<FIFO_DEPTH), registered level.
//  FSM IDLE->START->DATA->[PARITY]->STOP->IDLE (or START if FIFO non-empty).
//   IDLE: if fifo_level>0, pop head, latch word and clk_div; ser_tx low next edge.
//   Latency: push into empty FIFO at edge N -> start bit driven from edge N+1.
//   Each bit held exactly clk_div+1 clocks; clk_div changes mid-frame ignored.
//   DATA: LSB first, DATA_BITS bits. PARITY: even = XOR of data bits,
//   odd = inverted XOR. STOP: STOP_BITS bit periods of 1.
//   End of last stop bit: tx_done=1 for one clock; if FIFO non-empty the next
//   pop happens same edge -> start bit follows with zero idle gap.
//  Simultaneous push+pop: level unchanged, both take effect.
//  tx_clear: at next edge FIFO emptied, level=0; a push in same cycle is
//   dropped (clear wins); frame in flight completes normally.
//  tx_busy = (FSM!=IDLE) || (fifo_level!=0); registered alongside FSM.
//  Pointers wrap modulo FIFO_DEPTH; fifo_level never exceeds FIFO_DEPTH.
// TESTING
//  T1: PARITY=0, clk_div=3, push 0x3D -> ser_tx 0,1,0,1,1,1,1,0,0,1 each 4 clocks,
//      start bit on edge after push, tx_done at clock 40, tx_busy low after.
//  T2: PARITY=1, STOP_BITS=2, clk_div=3, push 0x3D -> parity bit 1, 12 bits
//      = 48 clocks; PARITY=2 same word -> parity bit 0.
//  T3: FIFO_DEPTH=8, clk_div=3, 10 back-to-back pushes 0x00..0x09 -> tx_ready
//      low after 9th accept (level 8), 10th accepted on first pop after frame 1;
//      10 frames in order, no idle gap, 400 clocks total.
//  T4: queue 5 words, assert tx_clear during frame 1 together with a push ->
//      frame 1 completes, level=0, no further frames, pushed word lost.
//  T5: resetb low mid data bit -> ser_tx=1, tx_busy=0, level=0 immediately;
//      after release, push 0xA5 -> clean frame.
//  T6: clk_div=0 -> 1 clock per bit, frame 10 clocks; clk_div=346 @ 40 MHz ->
//      bit period 347 clocks (115200 baud), checked by bench tbuart receiver.

Source files
------------

// File: rtl/uart_tx_queue.sv
// UART transmitter fed by a FIFO: words pushed with valid/ready are sent
// back-to-back on ser_tx with a runtime divisor, optional parity and 1/2 stop bits.
module uart_tx_queue #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_WIDTH  = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                          clock,
    input  logic                          resetb,
    input  logic [DIV_WIDTH-1:0]          clk_div,
    input  logic                          tx_valid,
    input  logic [DATA_BITS-1:0]          tx_data,
    output logic                          tx_ready,
    input  logic                          tx_clear,
    output logic                          ser_tx,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]        level_q, level_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 ser_q, ser_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 push, pop, bit_end, frame_end;
    logic [DATA_BITS-1:0] head;

    assign tx_ready   = (level_q < LW'(FIFO_DEPTH));
    assign push       = tx_valid && tx_ready && !tx_clear;
    assign head       = mem_q[rd_ptr_q];
    assign bit_end    = (cnt_q == div_q);
    assign ser_tx     = ser_q;
    assign tx_busy    = busy_q;
    assign tx_done    = done_q;
    assign fifo_level = level_q;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            div_q    <= '0;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            ser_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            ser_q    <= ser_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= tx_data;
    end

    // The end of the last stop bit pops the next word directly so frames abut.
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        frame_end = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (level_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_end && bit_q == BW'(DATA_BITS - 1))
                    state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (bit_end && bit_q == BW'(STOP_BITS - 1)) begin
                    frame_end = 1'b1;
                    if (level_q != '0) begin
                        pop     = 1'b1;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (tx_clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            level_d = level_q + LW'(push) - LW'(pop);
        end

        div_d   = div_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        if (pop) begin
            // Divisor is sampled once per frame so mid-frame changes are ignored.
            div_d   = clk_div;
            cnt_d   = '0;
            bit_d   = '0;
            shift_d = head;
            par_d   = (PARITY == 2) ? ~^head : ^head;
        end else if (state_q != S_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
            if (state_d != state_q) bit_d = '0;
            else if (bit_end)       bit_d = bit_q + 1'b1;
            if (state_q == S_DATA && bit_end) shift_d = shift_q >> 1;
        end
    end

    always_comb begin
        ser_d = 1'b1;
        case (state_d)
            S_START:  ser_d = 1'b0;
            S_DATA:   ser_d = shift_d[0];
            S_PARITY: ser_d = par_q;
            default:  ser_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE) || (level_d != '0);
        done_d = frame_end;
    end

endmodule
